// File: rtl/mips_defs.sv
// Shared MIPS decode constants: ALUOp codes, R-type Funct codes and the
// multiply/divide sequencer state encoding.
package mips_defs;

    localparam logic [1:0] ALUOP_MEM    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] R_TYPE       = 2'b10;

    // Funct codes shared with the ULA controller
    localparam logic [5:0] FUNCT_ADD   = 6'b100000;
    localparam logic [5:0] FUNCT_SUB   = 6'b100010;
    localparam logic [5:0] FUNCT_AND   = 6'b100100;
    localparam logic [5:0] FUNCT_OR    = 6'b100101;
    localparam logic [5:0] FUNCT_SLT   = 6'b101010;
    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
    localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FIX  = 2'd2
    } md_state_t;

endpackage

// File: rtl/muldiv_core.sv
// Iterative unsigned datapath: one shift-add multiply step or one restoring
// divide step per cycle on a shared double-width accumulator.
module muldiv_core #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  step,
    input  logic                  op_is_div,
    input  logic [DATA_W-1:0]     opa,
    input  logic [DATA_W-1:0]     opb,
    output logic [2*DATA_W-1:0]   acc
);

    // Multiply: acc = {partial product, multiplier}, opnd = multiplicand.
    // Divide:   acc = {remainder, dividend->quotient}, opnd = divisor.
    logic [DATA_W-1:0]   opnd;
    logic [DATA_W:0]     add_sum;
    logic [DATA_W:0]     shifted;
    logic                fits;
    logic [DATA_W-1:0]   diff;
    logic [2*DATA_W-1:0] acc_next;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        acc_next = acc;
        add_sum  = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, opnd} : '0);
        shifted  = acc[2*DATA_W-1:DATA_W-1];
        fits     = (shifted >= {1'b0, opnd});
        // When the divisor fits, the true difference is below the divisor, so DATA_W bits hold it.
        diff     = shifted[DATA_W-1:0] - opnd;
        if (op_is_div) begin
            if (fits)
                acc_next = {diff, acc[DATA_W-2:0], 1'b1};
            else
                acc_next = {shifted[DATA_W-1:0], acc[DATA_W-2:0], 1'b0};
        end else begin
            acc_next = {add_sum, acc[DATA_W-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (reset) begin
            acc  <= '0;
            opnd <= '0;
        end else if (load) begin
            opnd <= op_is_div ? opb : opa;
            acc  <= op_is_div ? {{DATA_W{1'b0}}, opa} : {{DATA_W{1'b0}}, opb};
        end else if (step) begin
            acc  <= acc_next;
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer: decodes MULT/DIV/MFxx/MTxx, runs the iterative
// core for 32 cycles while stalling the datapath, and owns HI/LO.
module muldiv_ctrl
    import mips_defs::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        ALUOp,
    input  logic [5:0]        Funct,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    output logic              stall,
    output logic              busy,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic [DATA_W-1:0] mf_data,
    output logic              mf_valid
);

    md_state_t state, state_next;
    logic [CNT_W-1:0] cnt;
    logic op_div, neg_q, neg_r, div_zero;
    logic start;

    logic is_r, dec_mul, dec_div, dec_signed;
    logic dec_mthi, dec_mtlo, dec_mfhi, dec_mflo;
    logic rs_neg, rt_neg;
    logic [DATA_W-1:0] rs_mag, rt_mag;

    assign is_r       = (ALUOp == R_TYPE);
    assign dec_mul    = is_r && (Funct == FUNCT_MULT || Funct == FUNCT_MULTU);
    assign dec_div    = is_r && (Funct == FUNCT_DIV  || Funct == FUNCT_DIVU);
    assign dec_signed = (Funct == FUNCT_MULT || Funct == FUNCT_DIV);
    assign dec_mthi   = is_r && (Funct == FUNCT_MTHI);
    assign dec_mtlo   = is_r && (Funct == FUNCT_MTLO);
    assign dec_mfhi   = is_r && (Funct == FUNCT_MFHI);
    assign dec_mflo   = is_r && (Funct == FUNCT_MFLO);

    assign rs_neg = dec_signed && rs_data[DATA_W-1];
    assign rt_neg = dec_signed && rt_data[DATA_W-1];
    assign rs_mag = rs_neg ? -rs_data : rs_data;
    assign rt_mag = rt_neg ? -rt_data : rt_data;

    logic [2*DATA_W-1:0] acc;

    muldiv_core #(.DATA_W(DATA_W)) u_core (
        .clk       (clk),
        .reset     (reset),
        .load      (start),
        .step      (state == BUSY),
        .op_is_div (start ? dec_div : op_div),
        .opa       (rs_mag),
        .opb       (rt_mag),
        .acc       (acc)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Decode is honoured only in IDLE, so the issuing instruction that is
    // still held in place during BUSY/FIX can never restart the engine.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        stall      = 1'b0;
        unique case (state)
            IDLE: begin
                if (!reset && (dec_mul || dec_div)) begin
                    start      = 1'b1;
                    stall      = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (cnt == '0) state_next = FIX;
            end
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    logic [2*DATA_W-1:0] prod_fix;
    logic [DATA_W-1:0]   quo, rem, quo_fix, rem_fix, res_hi, res_lo;

    // A zero divide leaves rem = |rs|, so restoring the dividend's sign
    // yields rs_data exactly; only the quotient's sign fix is suppressed.
    always_comb begin
        prod_fix = neg_q ? -acc : acc;
        quo      = acc[DATA_W-1:0];
        rem      = acc[2*DATA_W-1:DATA_W];
        quo_fix  = (neg_q && !div_zero) ? -quo : quo;
        rem_fix  = neg_r ? -rem : rem;
        res_hi   = op_div ? rem_fix : prod_fix[2*DATA_W-1:DATA_W];
        res_lo   = op_div ? quo_fix : prod_fix[DATA_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            op_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            if (start) begin
                cnt      <= CNT_W'(DATA_W - 1);
                op_div   <= dec_div;
                neg_q    <= rs_neg ^ rt_neg;
                neg_r    <= dec_div && rs_neg;
                div_zero <= dec_div && (rt_data == '0);
            end else if (state == BUSY) begin
                cnt <= cnt - 1'b1;
            end

            if (state == FIX) begin
                hi <= res_hi;
                lo <= res_lo;
            end else if (state == IDLE) begin
                if (dec_mthi) hi <= rs_data;
                if (dec_mtlo) lo <= rs_data;
            end
        end
    end

    assign mf_valid = dec_mfhi || dec_mflo;
    assign mf_data  = dec_mfhi ? hi : (dec_mflo ? lo : '0);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed-vector bench for muldiv_ctrl: hand-computed HI/LO results,
// stall length, MT/MF moves, non-R-type gating and mid-operation reset.
module tb_muldiv_ctrl;
    import mips_defs::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  ALUOp;
    logic [5:0]  Funct;
    logic [31:0] rs_data, rt_data;
    logic        stall, busy, mf_valid;
    logic [31:0] hi, lo, mf_data;

    int n_vec = 0;
    int n_bad = 0;

    muldiv_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .ALUOp    (ALUOp),
        .Funct    (Funct),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .stall    (stall),
        .busy     (busy),
        .hi       (hi),
        .lo       (lo),
        .mf_data  (mf_data),
        .mf_valid (mf_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Issue one mul/div, count stall cycles (bounded), then check HI/LO.
    task automatic run_op(input string tag, input logic [5:0] f,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        n = 0;
        @(negedge clk);
        ALUOp = R_TYPE; Funct = f; rs_data = a; rt_data = b;
        #1;
        while (stall && n < 100) begin
            n++;
            @(negedge clk);
            #1;
        end
        check({tag, " stall_cycles"}, 32'(n), 32'd33);
        check({tag, " busy_in_fix"}, {31'd0, busy}, 32'd1);
        ALUOp = ALUOP_MEM; Funct = 6'd0;
        @(negedge clk);
        #1;
        check({tag, " busy_done"}, {31'd0, busy}, 32'd0);
        check({tag, " hi"}, hi, exp_hi);
        check({tag, " lo"}, lo, exp_lo);
    endtask

    initial begin
        reset = 1'b1; ALUOp = 2'b00; Funct = 6'd0; rs_data = '0; rt_data = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst stall", {31'd0, stall}, 32'd0);
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst hi", hi, 32'd0);
        check("rst lo", lo, 32'd0);
        reset = 1'b0;

        run_op("multu max", FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult -3*7", FUNCT_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("divu 100/7", FUNCT_DIVU, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E);
        run_op("div -7/2",  FUNCT_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div ovf",   FUNCT_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        run_op("divu 5/0",  FUNCT_DIVU,  32'd5,         32'd0,         32'h0000_0005, 32'hFFFF_FFFF);
        run_op("div -5/0",  FUNCT_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF);

        // MTHI / MTLO followed by MFHI / MFLO
        @(negedge clk);
        ALUOp = R_TYPE; Funct = FUNCT_MTHI; rs_data = 32'h0000_1234;
        #1;
        check("mthi stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        Funct = FUNCT_MTLO; rs_data = 32'h0000_ABCD;
        @(negedge clk);
        Funct = FUNCT_MFHI; rs_data = 32'h0;
        #1;
        check("mfhi valid", {31'd0, mf_valid}, 32'd1);
        check("mfhi data", mf_data, 32'h0000_1234);
        check("mfhi stall", {31'd0, stall}, 32'd0);
        Funct = FUNCT_MFLO;
        #1;
        check("mflo data", mf_data, 32'h0000_ABCD);

        // MULT funct without R-type ALUOp must be ignored
        @(negedge clk);
        ALUOp = ALUOP_MEM; Funct = FUNCT_MULT; rs_data = 32'd9; rt_data = 32'd9;
        #1;
        check("nonr stall", {31'd0, stall}, 32'd0);
        check("nonr mf_valid", {31'd0, mf_valid}, 32'd0);
        check("nonr mf_data", mf_data, 32'd0);
        repeat (3) @(negedge clk);
        #1;
        check("nonr busy", {31'd0, busy}, 32'd0);
        check("nonr hi", hi, 32'h0000_1234);
        check("nonr lo", lo, 32'h0000_ABCD);

        // Reset during BUSY cycle 10 of a MULT
        @(negedge clk);
        ALUOp = R_TYPE; Funct = FUNCT_MULT; rs_data = 32'd5; rt_data = 32'd3;
        repeat (10) @(negedge clk);
        #1;
        check("mid busy", {31'd0, busy}, 32'd1);
        reset = 1'b1; ALUOp = ALUOP_MEM; Funct = 6'd0;
        @(negedge clk);
        #1;
        check("midrst stall", {31'd0, stall}, 32'd0);
        check("midrst busy", {31'd0, busy}, 32'd0);
        check("midrst hi", hi, 32'd0);
        check("midrst lo", lo, 32'd0);
        reset = 1'b0;

        run_op("multu 6*7", FUNCT_MULTU, 32'd6, 32'd7, 32'd0, 32'd42);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
Sequencer for the multiply/divide resource beside the main ULA in the MIPS monocycle datapath. It decodes R-type MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO from ALUOp and Funct. It runs a 32-iteration shift-add multiplier or restoring divider and owns the HI/LO registers. While an operation runs it asserts stall, which freezes the PC and register-file write enable so the issuing instruction stays in place until its result is ready.

Parameters:
DATA_W, 32, operand and HI/LO width
CNT_W, 5, iteration counter width (log2 DATA_W)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
ALUOp  in  2  from main control; only 2'b10 (R-type) enables decode
Funct  in  6  instruction bits 5-0
rs_data  in  DATA_W  register rs read value (multiplicand / dividend / MT source)
rt_data  in  DATA_W  register rt read value (multiplier / divisor)
stall  out  1  hold PC and suppress register-file write this cycle
busy  out  1  FSM not in IDLE
hi  out  DATA_W  HI register
lo  out  DATA_W  LO register
mf_data  out  DATA_W  HI for MFHI, LO for MFLO, else 0
mf_valid  out  1  current instruction is MFHI/MFLO; writeback mux selects mf_data

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (reset).
- Funct codes (decoded only when ALUOp = 2'b10):
  - MULT 011000, MULTU 011001, DIV 011010, DIVU 011011
  - MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011
  - All other codes: no action.
- Reset values: state = IDLE, hi = lo = 0, counter = 0, internal accumulators = 0, stall = 0, busy = 0.
- States: IDLE, BUSY, FIX.
- IDLE:
  - On a mul/div decode, latch the operands. For signed ops, latch the absolute values plus the sign flags (quotient negative = sign(rs) XOR sign(rt); remainder sign = sign(rs)).
  - Set counter = DATA_W-1 and go to BUSY.
  - stall = 1 combinationally in this issue cycle.
- BUSY:
  - Perform one iteration per cycle.
  - Multiply: shift-add into a 2*DATA_W product.
  - Divide: restoring shift-subtract, producing quotient and remainder.
  - Decrement the counter. When counter = 0, go to FIX.
  - stall = 1 throughout.
- FIX:
  - Apply sign correction.
    - Signed MULT: negate the 64-bit product if the signs differ.
    - Signed DIV: negate the quotient if its sign flag is set; negate the remainder if the dividend was negative.
  - Write HI/LO at the clock edge. Multiply: HI = product[63:32], LO = product[31:0]. Divide: LO = quotient, HI = remainder.
  - stall = 0, so the issuing instruction retires this cycle. Return to IDLE.
  - Decode is ignored in BUSY and FIX, so the still-present issuing instruction never re-triggers.
- Latency: issue cycle + 32 BUSY cycles + FIX = 34 cycles. stall is high for 33 of them. HI/LO are visible on the cycle after FIX.
- MTHI/MTLO: in IDLE, write rs_data into HI/LO at the clock edge. No stall.
- MFHI/MFLO: mf_data and mf_valid are combinational from the current HI/LO. No stall.
- busy = (state != IDLE).
- Divide by zero: no trap. Result is LO = all ones and HI = rs_data, for both DIV and DIVU. For signed ops the sign fix is suppressed.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0.
- Reset asserted in any state: the next cycle is IDLE with all outputs at reset values. Any partial result is discarded.

Decomposition:
- Shared constants header/package mips_defs:
  - ALUOp codes, including R_TYPE = 2'b10.
  - All Funct codes, shared with the ULA controller.
  - FSM state encoding.
- One natural sub-module, muldiv_core: the iterative datapath (accumulator/remainder registers, adder/subtractor, shift), driven by a step/load/op_is_div interface.
- muldiv_ctrl keeps decode, the FSM, the counter, sign handling and HI/LO.

Test Plan:
- MULTU rs = 0xFFFFFFFF, rt = 0xFFFFFFFF -> stall high exactly 33 cycles; afterwards HI = 0xFFFFFFFE, LO = 0x00000001.
- MULT rs = 0xFFFFFFFD (-3), rt = 7 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFEB. DIVU 100 / 7 -> LO = 0x0000000E, HI = 0x00000002.
- DIV rs = 0xFFFFFFF9 (-7), rt = 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0.
- DIVU 5 / 0 -> LO = 0xFFFFFFFF, HI = 5. DIV -5 / 0 -> LO = 0xFFFFFFFF, HI = 0xFFFFFFFB. No hang; busy returns to 0.
- MTHI rs = 0x1234 then MFHI -> mf_valid = 1, mf_data = 0x1234, stall = 0. Funct = MULT with ALUOp = 2'b00 -> no stall, HI/LO unchanged.
- Reset asserted on BUSY cycle 10 of a MULT -> next cycle stall = 0, busy = 0, HI = LO = 0. A following MULTU 6 * 7 -> LO = 42 after 34 cycles.
